blink_n_times_1: RTL and testbench



---
 rtl/bream_io_pkg.sv | 15 +
 rtl/phase_timer_1.sv | 29 ++
 rtl/blink_n_times_1.sv | 94 +++++++++
 tb/tb_blink_n_times_1.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bream_io_pkg.sv
// Shared Bream I/O definitions: FSM state encoding and
// default widths reused by the debounce and LED blocks.
package bream_io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned MSB_DEF   = 22;
  localparam int unsigned CNT_W_DEF = 8;

endpackage

// File: rtl/phase_timer_1.sv
// Free-running phase counter, msb+1 bits wide.
// Ports: clk, reset_n, clear (sync zero), tc (all-ones cycle).
module phase_timer_1
  import bream_io_pkg::*;
#(
  parameter int unsigned msb = MSB_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tc
);

  logic [msb:0] cnt_q;
  logic [msb:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign tc = &cnt_q;

endmodule

// File: rtl/blink_n_times_1.sv
// Blinks an LED count times (P on / P off) under the Bream handshake.
// Ports: clk, reset_n, start, count -> led, result, result_ready.
module blink_n_times_1
  import bream_io_pkg::*;
#(
  parameter int unsigned msb   = MSB_DEF,
  parameter int unsigned cnt_w = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [cnt_w-1:0] count,
  output logic             led,
  output logic [cnt_w-1:0] result,
  output logic             result_ready
);

  state_t           state_q;
  state_t           state_d;
  logic [cnt_w-1:0] rem_q;
  logic [cnt_w-1:0] rem_d;
  logic [cnt_w-1:0] res_q;
  logic [cnt_w-1:0] res_d;
  logic             clear;
  logic             tc;

  phase_timer_1 #(
    .msb     (msb)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .tc      (tc)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    res_d   = res_q;
    clear   = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = count;
          res_d   = '0;
          state_d = (count == '0) ? DONE : ON;
        end
      end
      ON: begin
        if (!start) begin
          state_d = IDLE;
        end else begin
          // tc clear only restates the natural wrap to zero
          clear = tc;
          if (tc) state_d = OFF;
        end
      end
      OFF: begin
        // an abort on the terminal edge does not credit the blink
        if (!start) begin
          state_d = IDLE;
        end else begin
          clear = tc;
          if (tc) begin
            res_d   = res_q + cnt_w'(1);
            rem_d   = rem_q - cnt_w'(1);
            state_d = (rem_q == cnt_w'(1)) ? DONE : ON;
          end
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
    end
  end

  assign led          = (state_q == ON);
  assign result       = res_q;
  assign result_ready = (state_q == DONE);

endmodule

// File: tb/tb_blink_n_times_1.sv
// Scoreboard bench for blink_n_times_1 with msb=2 (P=8).
// Expected output changes are queued per call; a monitor pops them.
module tb_blink_n_times_1;

  localparam int P  = 8;
  localparam int T2 = 2 * P;

  typedef struct {
    int kind;
    int cyc;
    int val;
  } ev_t;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] count;
  logic       led;
  logic [7:0] result;
  logic       result_ready;

  ev_t q[$];
  int  cyc    = 0;
  int  n_chk  = 0;
  int  n_fail = 0;
  bit  mon_en = 0;
  int  m_led  = 0;
  int  m_res  = 0;
  int  m_rdy  = 0;

  blink_n_times_1 #(
    .msb          (2),
    .cnt_w        (8)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .count        (count),
    .led          (led),
    .result       (result),
    .result_ready (result_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Outputs of an uninterrupted call, off cycles after the start edge.
  task automatic calc(input int off, input int n,
                      output int l, output int r, output int y);
    if (off >= n * T2) begin
      l = 0; r = n; y = 1;
    end else begin
      l = ((off % T2) < P) ? 1 : 0;
      r = off / T2;
      y = 0;
    end
  endtask

  // Queue every output change for a call started at edge k and
  // released (start seen low) at edge a.
  task automatic model_call(input int k, input int n, input int a);
    int l, r, y, rr;
    for (int t = k; t <= a; t++) begin
      if (t < a) begin
        calc(t - k, n, l, r, y);
      end else begin
        calc(a - 1 - k, n, l, rr, y);
        l = 0; y = 0; r = rr;
      end
      if (l != m_led) q.push_back('{0, t, l});
      if (r != m_res) q.push_back('{1, t, r});
      if (y != m_rdy) q.push_back('{2, t, y});
      m_led = l; m_res = r; m_rdy = y;
    end
  endtask

  task automatic dchk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, exp);
    end
  endtask

  task automatic mchk(input int kind, input int val);
    ev_t e;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_change kind=%0d cyc=%0d got=%0d required=none",
               kind, cyc, val);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.val != val) begin
        n_fail++;
        $display("FAIL out_change got kind=%0d cyc=%0d val=%0d required kind=%0d cyc=%0d val=%0d",
                 kind, cyc, val, e.kind, e.cyc, e.val);
      end
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    int s_led, s_res, s_rdy;
    int p_led, p_res, p_rdy;
    p_led = 0; p_res = 0; p_rdy = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      s_led = int'(led);
      s_res = int'(result);
      s_rdy = int'(result_ready);
      if (mon_en) begin
        if (s_led != p_led) mchk(0, s_led);
        if (s_res != p_res) mchk(1, s_res);
        if (s_rdy != p_rdy) mchk(2, s_rdy);
      end
      p_led = s_led; p_res = s_res; p_rdy = s_rdy;
    end
  end

  // Called at a falling edge; start held for a_off edges.
  task automatic run_call(input int n, input int a_off);
    int k;
    k = cyc + 1;
    count = 8'(n);
    start = 1'b1;
    model_call(k, n, k + a_off);
    repeat (a_off) begin
      @(negedge clk);
      count = 8'($urandom_range(0, 255));
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n, a_off;
    reset_n = 1'b0;
    start   = 1'b0;
    count   = '0;
    #1;
    dchk("reset_led", int'(led), 0);
    dchk("reset_result", int'(result), 0);
    dchk("reset_ready", int'(result_ready), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Mid-ON asynchronous reset with start held.
    count = 8'd3;
    start = 1'b1;
    repeat (3) @(negedge clk);
    dchk("led_mid_on", int'(led), 1);
    #2 reset_n = 1'b0;
    #1;
    dchk("async_rst_led", int'(led), 0);
    dchk("async_rst_result", int'(result), 0);
    dchk("async_rst_ready", int'(result_ready), 0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    run_call(3, 3 * T2 + 3);

    run_call(0, 3);
    run_call(5, T2 + 4);
    run_call(2, 2 * T2 + 2);
    run_call(2, 2 * T2 + 10);
    run_call(1, T2 + 2);
    run_call(255, 255 * T2 + 1);

    for (int i = 0; i < 20; i++) begin
      n = $urandom_range(0, 6);
      if ($urandom_range(0, 1) == 1) a_off = n * T2 + $urandom_range(1, 5);
      else a_off = $urandom_range(1, n * T2 + 5);
      run_call(n, a_off);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    dchk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
